// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared state encoding, default constants and tolerance helper for blink_monitor
package blink_pkg;

    localparam int unsigned DEF_NOMINAL     = 32'd50000000;
    localparam int unsigned DEF_TOL         = 32'd500000;
    localparam int unsigned DEF_TIMEOUT_CYC = 32'd100000000;
    localparam int unsigned DEF_LOCK_N      = 32'd3;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOST   = 2'd2
    } state_t;

    // Window check done in 33 bits so NOMINAL+TOL cannot wrap; the low bound clamps at zero.
    function automatic logic in_tol(input logic [31:0] p,
                                    input logic [32:0] nom,
                                    input logic [32:0] tol);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = (nom > tol) ? (nom - tol) : 33'd0;
        hi = nom + tol;
        return ({1'b0, p} >= lo) && ({1'b0, p} <= hi);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with registered rising-edge pulse
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s1;
    logic s2;
    logic s2_d;

    assign q = s2;

    // Synchronize d, keep a delayed copy, and register the rise so downstream sees a clean pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s2_d <= s2;
            rise <= s2 & ~s2_d;
        end
    end

endmodule

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - measures blink input period, tracks lock and flags loss of input
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned NOMINAL     = DEF_NOMINAL,
    parameter int unsigned TOL         = DEF_TOL,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned LOCK_N      = DEF_LOCK_N
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        blink_in,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic        timeout
);

    localparam int GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [31:0]   TO_LIM   = 32'(TIMEOUT_CYC);
    localparam logic [GW-1:0] LOCK_LIM = GW'(LOCK_N);

    state_t        state;
    logic [31:0]   cnt;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_inc;
    logic          rise;
    logic          blink_sync_unused;
    logic          cnt_in_tol;

    sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (blink_in),
        .q    (blink_sync_unused),
        .rise (rise)
    );

    assign cnt_in_tol = in_tol(cnt, 33'(NOMINAL), 33'(TOL));
    assign good_inc   = (good_cnt == LOCK_LIM) ? good_cnt : good_cnt + GW'(1);

    // Period measurement FSM: arm on first edge, measure edge-to-edge, fall to LOST when edges stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_SEARCH;
            cnt          <= 32'd0;
            good_cnt     <= '0;
            period       <= 32'd0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    cnt <= 32'd0;
                    if (rise) begin
                        state <= ST_TRACK;
                        cnt   <= 32'd1;
                    end
                end
                ST_TRACK: begin
                    if (rise) begin
                        // An edge takes priority over the timeout in the same cycle.
                        period       <= cnt;
                        period_valid <= 1'b1;
                        cnt          <= 32'd1;
                        if (cnt_in_tol) begin
                            good_cnt <= good_inc;
                            locked   <= (good_inc == LOCK_LIM);
                        end else begin
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    end else if (cnt >= TO_LIM) begin
                        state    <= ST_LOST;
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_LOST: begin
                    if (rise) begin
                        state   <= ST_TRACK;
                        cnt     <= 32'd1;
                        timeout <= 1'b0;
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - scoreboard bench for blink_monitor with randomized edge gaps
module tb_blink_monitor;

    localparam int NOM  = 100;
    localparam int TOLP = 5;
    localparam int TO   = 250;
    localparam int LN   = 3;

    localparam int K_PER   = 0;
    localparam int K_TOSET = 1;
    localparam int K_TOCLR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        blink_in;
    logic [31:0] period;
    logic        period_valid;
    logic        locked;
    logic        timeout;

    blink_monitor #(
        .NOMINAL     (NOM),
        .TOL         (TOLP),
        .TIMEOUT_CYC (TO),
        .LOCK_N      (LN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blink_in     (blink_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          at;
        logic [31:0] per;
        logic        lk;
    } ev_t;

    ev_t sb[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    // reference model state
    bit          armed    = 1'b0;
    bit          lost     = 1'b0;
    int          last_c   = 0;
    int          good     = 0;
    bit          m_locked = 1'b0;
    logic [31:0] last_per = 32'd0;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit tol_ok(int p);
        return (p >= NOM - TOLP) && (p <= NOM + TOLP);
    endfunction

    function automatic void observe(int k);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.at);
        chk("period", period, e.per);
        chk("locked", locked, e.lk);
        chk("timeout", timeout, (e.kind == K_TOSET) ? 1 : 0);
    endfunction

    // Wait g cycles from the previous edge, then raise blink_in and predict the outcome.
    task automatic send_edge(input int g);
        int p;
        if (armed && !lost && g > TO) begin
            sb.push_back('{K_TOSET, last_c + 4 + TO, last_per, 1'b0});
            lost     = 1'b1;
            good     = 0;
            m_locked = 1'b0;
        end
        for (int i = 1; i <= g; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) blink_in = 1'b0;
        end
        blink_in = 1'b1;
        if (!armed) begin
            armed = 1'b1;
        end else if (lost) begin
            sb.push_back('{K_TOCLR, cyc + 4, last_per, 1'b0});
            lost = 1'b0;
        end else begin
            p        = cyc - last_c;
            good     = tol_ok(p) ? ((good < LN) ? good + 1 : LN) : 0;
            m_locked = (good == LN);
            last_per = 32'(p);
            sb.push_back('{K_PER, cyc + 4, last_per, m_locked});
        end
        last_c = cyc;
    endtask

    task automatic reset_mid();
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) blink_in = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_period", period, 0);
        chk("rst_mid_valid", period_valid, 0);
        chk("rst_mid_locked", locked, 0);
        chk("rst_mid_timeout", timeout, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        armed    = 1'b0;
        lost     = 1'b0;
        good     = 0;
        m_locked = 1'b0;
        last_per = 32'd0;
    endtask

    // Monitor: pop the scoreboard whenever the DUT reports a period or a timeout transition.
    initial begin
        bit prev_to;
        prev_to = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (period_valid)         observe(K_PER);
                if (timeout && !prev_to)  observe(K_TOSET);
                if (!timeout && prev_to)  observe(K_TOCLR);
            end
            prev_to = timeout;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        blink_in = 1'b0;
        #12;
        chk("reset_period", period, 0);
        chk("reset_valid", period_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_timeout", timeout, 0);
        @(posedge clk);
        #3 rst = 1'b0;

        repeat (5) send_edge(NOM);
        send_edge(110);
        repeat (3) send_edge(NOM);
        send_edge(95);
        send_edge(105);
        send_edge(94);
        send_edge(NOM);
        send_edge(106);
        send_edge(TO);
        repeat (3) send_edge(NOM);
        send_edge(TO + 50);
        repeat (4) send_edge(NOM);
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) send_edge($urandom_range(240, 270));
            else        send_edge($urandom_range(92, 108));
        end

        reset_mid();
        send_edge(30);
        send_edge(NOM);
        send_edge(NOM);
        repeat (3) send_edge(NOM);

        if (armed && !lost) begin
            sb.push_back('{K_TOSET, last_c + 4 + TO, last_per, 1'b0});
            lost = 1'b1;
        end
        repeat (TO + 20) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
